voice_phase_scheduler: RTL and testbench

- Polyphonic voice allocator and sequencer for a single shared phase-accumulator datapath.
- Accepts note-on/note-off events and assigns notes to NUM_VOICES voice slots.
- On each internal sample tick, sweeps all voices through one shared 32-bit adder, emitting one phase word per voice per frame.
- Sits between the note decoder and the wave lookup (sine/BRAM) stage.

---
 rtl/voice_phase_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_voice_phase_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_phase_scheduler.sv
// Polyphonic voice allocator that sweeps every voice through one shared phase adder per sample tick.
// Build option: define VOICE_STEAL_EN to let a note-on steal the oldest voice when every voice is busy.
module voice_phase_scheduler #(
  parameter int NUM_VOICES    = 4,
  parameter int PHASE_WIDTH   = 32,
  parameter int SAMPLE_PERIOD = 6104,
  localparam int VW = $clog2(NUM_VOICES),
  localparam int CW = $clog2(SAMPLE_PERIOD)
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   event_valid_in,
  output logic                   event_ready_out,
  input  logic                   event_on_in,
  input  logic [7:0]             note_in,
  output logic                   phase_valid_out,
  output logic [VW-1:0]          phase_voice_out,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic                   frame_done_out,
  output logic [NUM_VOICES-1:0]  voice_active_out,
  output logic                   note_dropped_out
);

  typedef enum logic [1:0] {IDLE, EVENT, SCAN} state_t;

  function automatic logic [31:0] incRaw(input logic [7:0] n);
    logic [31:0] inc;
    case (n)
      8'd60:   inc = 32'd112404;
      8'd62:   inc = 32'd126156;
      8'd64:   inc = 32'd141526;
      8'd65:   inc = 32'd149664;
      8'd67:   inc = 32'd167772;
      8'd69:   inc = 32'd188743;
      8'd71:   inc = 32'd211688;
      8'd72:   inc = 32'd224003;
      default: inc = 32'd0;
    endcase
    return inc;
  endfunction

  state_t                 state_q, state_d;
  logic                   pending_q, pending_d;
  logic [CW-1:0]          tickCnt_q;
  logic [VW-1:0]          scanIdx_q;
  logic                   ready_q;
  logic                   phaseValid_q;
  logic [VW-1:0]          phaseVoice_q;
  logic [PHASE_WIDTH-1:0] phaseOut_q;
  logic                   frameDone_q;
  logic                   dropped_q;
  logic [NUM_VOICES-1:0]  active_q;
  logic [PHASE_WIDTH-1:0] phase_q [NUM_VOICES];
  logic [7:0]             note_q  [NUM_VOICES];
  logic [VW-1:0]          age_q   [NUM_VOICES];
  logic [7:0]             evNote_q;
  logic [VW-1:0]          evIdx_q;
  logic                   evAlloc_q;
  logic                   evClear_q;

  logic                   tickHit, accept, lastVoice;
  logic                   matchHit, freeHit;
  logic [VW-1:0]          matchIdx, freeIdx, targetIdx;
  logic                   allocDo, clearDo, dropDo;
  logic [PHASE_WIDTH-1:0] sumPhase, newPhase;
`ifdef VOICE_STEAL_EN
  logic [VW-1:0]          oldestIdx;
`endif

  always_comb begin
    tickHit   = (tickCnt_q == CW'(SAMPLE_PERIOD - 1));
    accept    = event_valid_in && ready_q;
    lastVoice = (scanIdx_q == VW'(NUM_VOICES - 1));
    state_d   = state_q;
    pending_d = pending_q | tickHit;
    case (state_q)
      IDLE: begin
        if (pending_q) begin
          state_d   = SCAN;
          pending_d = tickHit;
        end else if (accept) begin
          state_d = EVENT;
        end
      end
      EVENT:   state_d = IDLE;
      SCAN:    if (lastVoice) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The allocation decision is made against the incoming event so that EVENT only applies it;
  // voices cannot change between acceptance and EVENT.
  always_comb begin
    matchHit  = 1'b0;
    matchIdx  = '0;
    freeHit   = 1'b0;
    freeIdx   = '0;
`ifdef VOICE_STEAL_EN
    oldestIdx = '0;
`endif
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (active_q[i] && note_q[i] == note_in) begin
        matchHit = 1'b1;
        matchIdx = VW'(i);
      end
      if (!active_q[i]) begin
        freeHit = 1'b1;
        freeIdx = VW'(i);
      end
`ifdef VOICE_STEAL_EN
      if (age_q[i] == VW'(NUM_VOICES - 1)) oldestIdx = VW'(i);
`endif
    end
    allocDo   = 1'b0;
    clearDo   = 1'b0;
    dropDo    = 1'b0;
    targetIdx = matchIdx;
    if (event_on_in) begin
      if (incRaw(note_in) != 32'd0) begin
        if (matchHit) begin
          allocDo = 1'b1;
        end else if (freeHit) begin
          allocDo   = 1'b1;
          targetIdx = freeIdx;
        end else begin
`ifdef VOICE_STEAL_EN
          allocDo   = 1'b1;
          targetIdx = oldestIdx;
`else
          dropDo = 1'b1;
`endif
        end
      end
    end else begin
      clearDo = matchHit;
    end
  end

  always_comb begin
    sumPhase = phase_q[scanIdx_q] + PHASE_WIDTH'(incRaw(note_q[scanIdx_q]));
    newPhase = active_q[scanIdx_q] ? sumPhase : '0;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      tickCnt_q    <= '0;
      scanIdx_q    <= '0;
      ready_q      <= 1'b0;
      phaseValid_q <= 1'b0;
      phaseVoice_q <= '0;
      phaseOut_q   <= '0;
      frameDone_q  <= 1'b0;
      dropped_q    <= 1'b0;
      active_q     <= '0;
      evNote_q     <= '0;
      evIdx_q      <= '0;
      evAlloc_q    <= 1'b0;
      evClear_q    <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase_q[i] <= '0;
        note_q[i]  <= '0;
        age_q[i]   <= VW'(i);
      end
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      ready_q      <= (state_d == IDLE) && !pending_d;
      tickCnt_q    <= tickHit ? '0 : tickCnt_q + CW'(1);
      phaseValid_q <= 1'b0;
      frameDone_q  <= 1'b0;
      dropped_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pending_q) begin
            scanIdx_q <= '0;
          end else if (accept) begin
            evNote_q  <= note_in;
            evIdx_q   <= targetIdx;
            evAlloc_q <= allocDo;
            evClear_q <= clearDo;
            dropped_q <= dropDo;
          end
        end
        EVENT: begin
          if (evAlloc_q) begin
            note_q[evIdx_q]   <= evNote_q;
            phase_q[evIdx_q]  <= '0;
            active_q[evIdx_q] <= 1'b1;
            // Promote to most recent; only voices younger than it age by one.
            for (int j = 0; j < NUM_VOICES; j++) begin
              if (VW'(j) == evIdx_q) age_q[j] <= '0;
              else if (age_q[j] < age_q[evIdx_q]) age_q[j] <= age_q[j] + VW'(1);
            end
          end
          if (evClear_q) begin
            active_q[evIdx_q] <= 1'b0;
            phase_q[evIdx_q]  <= '0;
          end
        end
        SCAN: begin
          phase_q[scanIdx_q] <= newPhase;
          phaseValid_q       <= 1'b1;
          phaseVoice_q       <= scanIdx_q;
          phaseOut_q         <= newPhase;
          frameDone_q        <= lastVoice;
          scanIdx_q          <= scanIdx_q + VW'(1);
        end
        default: ;
      endcase
    end
  end

  assign event_ready_out  = ready_q;
  assign phase_valid_out  = phaseValid_q;
  assign phase_voice_out  = phaseVoice_q;
  assign phase_out        = phaseOut_q;
  assign frame_done_out   = frameDone_q;
  assign voice_active_out = active_q;
  assign note_dropped_out = dropped_q;

endmodule

// File: tb/tb_voice_phase_scheduler.sv
// Scoreboard bench for voice_phase_scheduler: directed note events, expected phase beats queued per frame.
// A 24-bit phase keeps the phase-wrap scenario short; wrap behaviour is identical at any width.
module tb_voice_phase_scheduler;
  localparam int NV = 4;
  localparam int PW = 24;
  localparam int SP = 16;

  logic          clk = 1'b0;
  logic          rstN = 1'b0;
  logic          evValid = 1'b0;
  logic          evOn = 1'b0;
  logic [7:0]    evNote = 8'd0;
  logic          event_ready_out;
  logic          phase_valid_out;
  logic [1:0]    phase_voice_out;
  logic [PW-1:0] phase_out;
  logic          frame_done_out;
  logic [NV-1:0] voice_active_out;
  logic          note_dropped_out;

  voice_phase_scheduler #(.NUM_VOICES(NV), .PHASE_WIDTH(PW), .SAMPLE_PERIOD(SP)) dut (
    .clk_in(clk), .rst_n_in(rstN),
    .event_valid_in(evValid), .event_ready_out(event_ready_out),
    .event_on_in(evOn), .note_in(evNote),
    .phase_valid_out(phase_valid_out), .phase_voice_out(phase_voice_out),
    .phase_out(phase_out), .frame_done_out(frame_done_out),
    .voice_active_out(voice_active_out), .note_dropped_out(note_dropped_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    voice;
    logic [PW-1:0] phase;
    logic          last;
  } beat_t;

  beat_t         expQ[$];
  int            nVectors = 0;
  int            nMiscompares = 0;
  logic [PW-1:0] mPhase [NV];
  logic [7:0]    mNote  [NV];
  logic [NV-1:0] mActive;
  logic [PW-1:0] lastPhase [NV];

  function automatic logic [PW-1:0] incOf(input logic [7:0] n);
    case (n)
      8'd60:   return 24'd112404;
      8'd62:   return 24'd126156;
      8'd64:   return 24'd141526;
      8'd65:   return 24'd149664;
      8'd67:   return 24'd167772;
      8'd69:   return 24'd188743;
      8'd71:   return 24'd211688;
      8'd72:   return 24'd224003;
      default: return 24'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nVectors++;
    if (actual !== required) begin
      nMiscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, required, $time);
    end
  endtask

  // Monitor: every valid beat must match the oldest queued expectation.
  always @(negedge clk) begin
    if (phase_valid_out) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected beat", {31'd0, phase_valid_out}, 32'd0);
      end else begin
        beat_t e;
        e = expQ.pop_front();
        checkOutput("beat voice", {30'd0, phase_voice_out}, {30'd0, e.voice});
        checkOutput("beat phase", {8'd0, phase_out}, {8'd0, e.phase});
        checkOutput("beat frame_done", {31'd0, frame_done_out}, {31'd0, e.last});
        lastPhase[phase_voice_out] = phase_out;
      end
    end
  end

  task automatic modelReset();
    mActive = '0;
    for (int i = 0; i < NV; i++) begin
      mPhase[i] = '0;
      mNote[i] = 8'd0;
      lastPhase[i] = '0;
    end
  endtask

  task automatic pushFrame();
    for (int v = 0; v < NV; v++) begin
      beat_t b;
      mPhase[v] = mActive[v] ? mPhase[v] + incOf(mNote[v]) : '0;
      b.voice = 2'(v);
      b.phase = mPhase[v];
      b.last  = (v == NV - 1);
      expQ.push_back(b);
    end
  endtask

  task automatic waitFrame();
    int waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!frame_done_out && waited < 64);
    if (!frame_done_out) checkOutput("frame timeout", {31'd0, frame_done_out}, 32'd1);
  endtask

  task automatic runFrame();
    pushFrame();
    waitFrame();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " valid"}, {31'd0, phase_valid_out}, 32'd0);
    checkOutput({tag, " voice"}, {30'd0, phase_voice_out}, 32'd0);
    checkOutput({tag, " phase"}, {8'd0, phase_out}, 32'd0);
    checkOutput({tag, " frame_done"}, {31'd0, frame_done_out}, 32'd0);
    checkOutput({tag, " active"}, {28'd0, voice_active_out}, 32'd0);
    checkOutput({tag, " dropped"}, {31'd0, note_dropped_out}, 32'd0);
    checkOutput({tag, " ready"}, {31'd0, event_ready_out}, 32'd0);
  endtask

  // expVoice < 0 means the event must leave every voice untouched.
  task automatic applyStimulus(input logic on, input logic [7:0] note, input int expVoice, input logic expDrop);
    int waited = 0;
    @(negedge clk);
    evValid = 1'b1;
    evOn    = on;
    evNote  = note;
    while (!event_ready_out && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!event_ready_out) begin
      checkOutput("event accept timeout", {31'd0, event_ready_out}, 32'd1);
      evValid = 1'b0;
      return;
    end
    @(negedge clk);
    evValid = 1'b0;
    checkOutput("note_dropped pulse", {31'd0, note_dropped_out}, {31'd0, expDrop});
    @(negedge clk);
    checkOutput("note_dropped cleared", {31'd0, note_dropped_out}, 32'd0);
    if (expVoice >= 0) begin
      if (on) begin
        mNote[expVoice]   = note;
        mPhase[expVoice]  = '0;
        mActive[expVoice] = 1'b1;
      end else begin
        mPhase[expVoice]  = '0;
        mActive[expVoice] = 1'b0;
      end
    end
    checkOutput("voice_active", {28'd0, voice_active_out}, {28'd0, mActive});
  endtask

  task automatic doReset();
    @(negedge clk);
    rstN = 1'b0;
    repeat (2) @(negedge clk);
    expQ.delete();
    modelReset();
    rstN = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, nothing expected");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int waited;
    modelReset();
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;

    // Idle frames: four zero beats, frame_done on voice 3.
    runFrame();
    runFrame();

    // A4 alone in voice 0; three frames accumulate 3*188743.
    applyStimulus(1'b1, 8'd69, 0, 1'b0);
    runFrame();
    runFrame();
    runFrame();
    checkOutput("A4 after 3 frames", {8'd0, lastPhase[0]}, 32'd566229);
    applyStimulus(1'b0, 8'd69, 0, 1'b0);
    runFrame();

    // Note-off frees voice 1, which the next note-on reclaims; unknown note-off is ignored.
    applyStimulus(1'b1, 8'd60, 0, 1'b0);
    applyStimulus(1'b1, 8'd62, 1, 1'b0);
    runFrame();
    applyStimulus(1'b0, 8'd62, 1, 1'b0);
    applyStimulus(1'b1, 8'd72, 1, 1'b0);
    runFrame();
    applyStimulus(1'b0, 8'd50, -1, 1'b0);
    runFrame();

    // Fill all voices, then overflow; voice 0 holds the oldest allocation.
    applyStimulus(1'b1, 8'd64, 2, 1'b0);
    applyStimulus(1'b1, 8'd65, 3, 1'b0);
    runFrame();
    applyStimulus(1'b1, 8'd50, -1, 1'b0);
`ifdef VOICE_STEAL_EN
    applyStimulus(1'b1, 8'd67, 0, 1'b0);
    runFrame();
    checkOutput("stolen voice phase", {8'd0, lastPhase[0]}, 32'd167772);
`else
    applyStimulus(1'b1, 8'd67, -1, 1'b1);
    runFrame();
`endif
    applyStimulus(1'b1, 8'd64, 2, 1'b0);
    runFrame();
    checkOutput("retrigger phase", {8'd0, lastPhase[2]}, 32'd141526);

    // Event raised in the cycle the tick goes pending: the frame runs first.
    pushFrame();
    repeat (11) @(negedge clk);
    checkOutput("ready while tick pending", {31'd0, event_ready_out}, 32'd0);
    evValid = 1'b1;
    evOn    = 1'b0;
    evNote  = 8'd72;
    waited  = 0;
    while (!event_ready_out && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("cycles until accept", waited, 32'd5);
    @(negedge clk);
    evValid = 1'b0;
    @(negedge clk);
    mActive[1] = 1'b0;
    mPhase[1]  = '0;
    checkOutput("active after deferred off", {28'd0, voice_active_out}, {28'd0, mActive});
    runFrame();

    // Long A4 run: 89*188743 wraps modulo 2^24 to 20911.
    doReset();
    runFrame();
    applyStimulus(1'b1, 8'd69, 0, 1'b0);
    for (int f = 0; f < 89; f++) runFrame();
    checkOutput("A4 wrapped phase", {8'd0, lastPhase[0]}, 32'd20911);

    // Reset in the middle of a sweep clears every output immediately.
    pushFrame();
    waited = 0;
    while (!phase_valid_out && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("mid-scan beat seen", {31'd0, phase_valid_out}, 32'd1);
    #1 rstN = 1'b0;
    #1 checkAllZero("async reset");
    expQ.delete();
    modelReset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    runFrame();
    checkOutput("active after reset", {28'd0, voice_active_out}, 32'd0);

    repeat (4) @(negedge clk);
    checkOutput("leftover expectations", expQ.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule
